xbar_cfg_sequencer: RTL and testbench

XBAR_CFG_SEQUENCER -- requirements
Module: xbar_cfg_sequencer

---
 rtl/xbar_cfg_sequencer.sv | 114 +++++++++++
 tb/tb_xbar_cfg_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_cfg_sequencer.sv
// rtl/xbar_cfg_sequencer.sv - round-robin crossbar reconfiguration sequencer
// Grants one config request, drains in-flight traffic, then hands the new control word to both crossbars.
module xbar_cfg_sequencer #(
  parameter int CONTROL_BIT_WIDTH = 2,
  parameter int CNT_WIDTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_val,
  input  logic [CONTROL_BIT_WIDTH-1:0] req0_msg,
  output logic                         req0_rdy,
  input  logic                         req1_val,
  input  logic [CONTROL_BIT_WIDTH-1:0] req1_msg,
  output logic                         req1_rdy,
  input  logic                         in_fire,
  input  logic                         out_fire,
  output logic [CONTROL_BIT_WIDTH-1:0] xbar_ctrl_msg,
  output logic                         xbar_ctrl_val_in,
  input  logic                         xbar_ctrl_rdy_in,
  output logic                         xbar_ctrl_val_out,
  input  logic                         xbar_ctrl_rdy_out,
  output logic                         hold,
  output logic [CONTROL_BIT_WIDTH-1:0] cur_cfg,
  output logic [CNT_WIDTH-1:0]         inflight,
  output logic                         err
);

  typedef enum logic [1:0] {IDLE, DRAIN, CONFIG} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                         state, state_nxt;
  logic                           rr_ptr;
  logic                           served;
  logic [CONTROL_BIT_WIDTH-1:0]   cfg_reg;
  logic                           gnt0, gnt1;
  logic                           cfg_done;

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    cfg_done  = 1'b0;
    case (state)
      IDLE: begin
        // rr_ptr picks the winner only on contention; a lone requester always wins
        gnt0 = req0_val & (~req1_val | ~rr_ptr);
        gnt1 = req1_val & (~req0_val | rr_ptr);
        if (gnt0 | gnt1) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_nxt = CONFIG;
      end
      CONFIG: begin
        cfg_done = (~xbar_ctrl_val_in | xbar_ctrl_rdy_in) & (~xbar_ctrl_val_out | xbar_ctrl_rdy_out);
        if (cfg_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdy is gated by reset so nothing is accepted while reset is held
  assign req0_rdy      = gnt0 & reset;
  assign req1_rdy      = gnt1 & reset;
  assign hold          = (state != IDLE);
  assign xbar_ctrl_msg = (state == CONFIG) ? cfg_reg : cur_cfg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      rr_ptr            <= 1'b0;
      served            <= 1'b0;
      cfg_reg           <= '0;
      cur_cfg           <= '0;
      xbar_ctrl_val_in  <= 1'b0;
      xbar_ctrl_val_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0) begin
        cfg_reg <= req0_msg;
        served  <= 1'b0;
      end else if (gnt1) begin
        cfg_reg <= req1_msg;
        served  <= 1'b1;
      end
      if (state == DRAIN && state_nxt == CONFIG) begin
        xbar_ctrl_val_in  <= 1'b1;
        xbar_ctrl_val_out <= 1'b1;
      end else begin
        if (xbar_ctrl_val_in && xbar_ctrl_rdy_in)   xbar_ctrl_val_in  <= 1'b0;
        if (xbar_ctrl_val_out && xbar_ctrl_rdy_out) xbar_ctrl_val_out <= 1'b0;
      end
      if (cfg_done) begin
        cur_cfg <= cfg_reg;
        rr_ptr  <= ~served;
      end
    end
  end

  // Saturating in-flight counter; err is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      err      <= 1'b0;
    end else if (in_fire && !out_fire) begin
      if (inflight == CNT_MAX) err <= 1'b1;
      else                     inflight <= inflight + 1'b1;
    end else if (out_fire && !in_fire) begin
      if (inflight == '0) err <= 1'b1;
      else                inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_cfg_sequencer.sv
// tb/tb_xbar_cfg_sequencer.sv - scoreboard bench for xbar_cfg_sequencer
module tb_xbar_cfg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_val, req1_val;
  logic [1:0] req0_msg, req1_msg;
  logic       req0_rdy, req1_rdy;
  logic       in_fire, out_fire;
  logic [1:0] xbar_ctrl_msg;
  logic       xbar_ctrl_val_in, xbar_ctrl_rdy_in;
  logic       xbar_ctrl_val_out, xbar_ctrl_rdy_out;
  logic       hold;
  logic [1:0] cur_cfg;
  logic [3:0] inflight;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] exp_q[$];
  logic [1:0] m_cur;
  int         m_inf;
  logic       m_err, m_ptr, prev_hold;

  xbar_cfg_sequencer dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_msg(req0_msg), .req0_rdy(req0_rdy),
    .req1_val(req1_val), .req1_msg(req1_msg), .req1_rdy(req1_rdy),
    .in_fire(in_fire), .out_fire(out_fire),
    .xbar_ctrl_msg(xbar_ctrl_msg),
    .xbar_ctrl_val_in(xbar_ctrl_val_in), .xbar_ctrl_rdy_in(xbar_ctrl_rdy_in),
    .xbar_ctrl_val_out(xbar_ctrl_val_out), .xbar_ctrl_rdy_out(xbar_ctrl_rdy_out),
    .hold(hold), .cur_cfg(cur_cfg), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0; in_fire = 1'b0; out_fire = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || hold) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_val_in(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!xbar_ctrl_val_in && n < budget);
    chk("val_in_timeout", 32'(xbar_ctrl_val_in), 32'd1);
  endtask

  // Request drivers present the head of each per-port stimulus queue
  initial begin
    req0_val = 1'b0; req0_msg = '0; req1_val = 1'b0; req1_msg = '0;
    forever begin
      @(posedge clk);
      #2;
      req0_val = (q0.size() != 0);
      if (q0.size() != 0) req0_msg = q0[0];
      req1_val = (q1.size() != 0);
      if (q1.size() != 0) req1_msg = q1[0];
    end
  end

  // Monitor: arbitration model, scoreboard of completed configs, counter model
  always @(negedge clk) begin
    logic k;
    if (!reset) begin
      exp_q.delete();
      m_inf = 0; m_err = 1'b0; m_cur = '0; m_ptr = 1'b0; prev_hold = 1'b0;
    end else begin
      if (prev_hold && !hold) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'd0, 32'd1);
        else m_cur = exp_q.pop_front();
      end
      prev_hold = hold;
      chk("inflight", 32'(inflight), 32'(m_inf));
      chk("err", 32'(err), 32'(m_err));
      chk("cur_cfg", 32'(cur_cfg), 32'(m_cur));
      if (xbar_ctrl_val_in || xbar_ctrl_val_out) begin
        if (exp_q.size() != 0) chk("msg_cfg", 32'(xbar_ctrl_msg), 32'(exp_q[0]));
      end else begin
        chk("msg_cur", 32'(xbar_ctrl_msg), 32'(m_cur));
      end
      if (hold) begin
        chk("rdy_busy", 32'(req0_rdy | req1_rdy), 32'd0);
      end else if (req0_val || req1_val) begin
        k = (req0_val && req1_val) ? m_ptr : req1_val;
        chk("rdy_count", 32'(req0_rdy) + 32'(req1_rdy), 32'd1);
        chk("grant_idx", 32'(req1_rdy), 32'(k));
        if (k == 1'b0 && q0.size() != 0) exp_q.push_back(q0.pop_front());
        if (k == 1'b1 && q1.size() != 0) exp_q.push_back(q1.pop_front());
        m_ptr = ~k;
      end
      if (in_fire && !out_fire) begin
        if (m_inf == 15) m_err = 1'b1;
        else m_inf++;
      end else if (out_fire && !in_fire) begin
        if (m_inf == 0) m_err = 1'b1;
        else m_inf--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_hi;
    reset = 1'b0; in_fire = 1'b0; out_fire = 1'b0;
    xbar_ctrl_rdy_in = 1'b1; xbar_ctrl_rdy_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_val_in", 32'(xbar_ctrl_val_in), 32'd0);
    chk("rst_val_out", 32'(xbar_ctrl_val_out), 32'd0);
    chk("rst_cur_cfg", 32'(cur_cfg), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Minimum latency: grant, one DRAIN cycle, one CONFIG cycle
    tick();
    q0.push_back(2'b10);
    @(negedge clk); chk("t1_rdy0_c0", 32'(req0_rdy), 32'd1);
    @(negedge clk); chk("t1_hold_c1", 32'(hold), 32'd1);
    chk("t1_val_c1", 32'(xbar_ctrl_val_in), 32'd0);
    @(negedge clk); chk("t1_val_in_c2", 32'(xbar_ctrl_val_in), 32'd1);
    chk("t1_val_out_c2", 32'(xbar_ctrl_val_out), 32'd1);
    chk("t1_msg_c2", 32'(xbar_ctrl_msg), 32'd2);
    @(negedge clk); chk("t1_hold_c3", 32'(hold), 32'd0);
    chk("t1_cur_c3", 32'(cur_cfg), 32'd2);

    // Contending requesters from reset alternate 0,1,0,1...
    do_reset();
    q0.push_back(2'd1); q0.push_back(2'd2); q0.push_back(2'd3);
    q1.push_back(2'd3); q1.push_back(2'd1); q1.push_back(2'd0);
    wait_idle(300);

    // Drain waits for three outstanding transfers
    tick(); in_fire = 1'b1;
    tick(); tick(); tick(); in_fire = 1'b0;
    q0.push_back(2'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("t3_hold", 32'(hold), 32'd1);
    chk("t3_inflight", 32'(inflight), 32'd3);
    chk("t3_val_wait", 32'(xbar_ctrl_val_in), 32'd0);
    tick(); out_fire = 1'b1;
    tick(); tick(); tick(); out_fire = 1'b0;
    @(negedge clk);
    chk("t3_inflight0", 32'(inflight), 32'd0);
    chk("t3_val_still_low", 32'(xbar_ctrl_val_in), 32'd0);
    chk("t3_hold_drain", 32'(hold), 32'd1);
    @(negedge clk);
    chk("t3_val_rise", 32'(xbar_ctrl_val_in), 32'd1);
    wait_idle(50);

    // Output crossbar stalls four cycles
    tick(); xbar_ctrl_rdy_out = 1'b0;
    q1.push_back(2'd3);
    wait_val_in(30);
    chk("t4_val_out_c0", 32'(xbar_ctrl_val_out), 32'd1);
    n_hi = xbar_ctrl_val_out ? 1 : 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) xbar_ctrl_rdy_out = 1'b1;
      @(negedge clk);
      if (i == 1) chk("t4_val_in_drop", 32'(xbar_ctrl_val_in), 32'd0);
      if (xbar_ctrl_val_out) n_hi++;
    end
    chk("t4_cur_held", 32'(cur_cfg), 32'd1);
    @(negedge clk);
    chk("t4_val_out_cycles", 32'(n_hi), 32'd5);
    chk("t4_val_out_drop", 32'(xbar_ctrl_val_out), 32'd0);
    chk("t4_hold_done", 32'(hold), 32'd0);
    chk("t4_cur_new", 32'(cur_cfg), 32'd3);

    // Counter saturation, simultaneous fires, underflow
    do_reset();
    tick(); in_fire = 1'b1;
    repeat (16) tick();
    in_fire = 1'b0;
    @(negedge clk);
    chk("t5_sat", 32'(inflight), 32'd15);
    chk("t5_ovf_err", 32'(err), 32'd1);
    tick(); in_fire = 1'b1; out_fire = 1'b1;
    tick(); tick(); in_fire = 1'b0; out_fire = 1'b0;
    @(negedge clk);
    chk("t5_both", 32'(inflight), 32'd15);
    chk("t5_err_sticky", 32'(err), 32'd1);
    tick(); out_fire = 1'b1;
    tick(); out_fire = 1'b0;
    @(negedge clk);
    chk("t5_dec", 32'(inflight), 32'd14);
    do_reset();
    tick(); out_fire = 1'b1;
    tick(); out_fire = 1'b0;
    @(negedge clk);
    chk("t5_unf_cnt", 32'(inflight), 32'd0);
    chk("t5_unf_err", 32'(err), 32'd1);
    do_reset();

    // Reset mid-CONFIG aborts; fresh request afterwards completes
    tick(); q0.push_back(2'd2);
    wait_idle(50);
    tick(); xbar_ctrl_rdy_out = 1'b0;
    q0.push_back(2'd3);
    wait_val_in(30);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_hold", 32'(hold), 32'd0);
    chk("t6_val_in", 32'(xbar_ctrl_val_in), 32'd0);
    chk("t6_val_out", 32'(xbar_ctrl_val_out), 32'd0);
    chk("t6_cur_cfg", 32'(cur_cfg), 32'd0);
    chk("t6_msg", 32'(xbar_ctrl_msg), 32'd0);
    chk("t6_inflight", 32'(inflight), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    tick(); q0.push_back(2'd1);
    @(posedge clk);
    #3;
    chk("t6_rdy_in_reset", 32'(req0_rdy), 32'd0);
    tick(); reset = 1'b1; xbar_ctrl_rdy_out = 1'b1;
    wait_idle(50);
    @(negedge clk);
    chk("t6_fresh_cfg", 32'(cur_cfg), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
